// File: rtl/uart_pkg.sv
// Shared constants, state encodings and parameter helpers for the 8N1 UART PHY.
package uart_pkg;

    localparam int unsigned DATA_BITS    = 8;
    localparam int unsigned OVERSAMPLE   = 16;
    localparam int unsigned SAMPLE_POINT = 8;

    // Both enums live in one package, so their enumerators carry an RX_/TX_ prefix.
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    function automatic int unsigned at_least_one(input int unsigned value);
        return (value == 0) ? 1 : value;
    endfunction

endpackage

// File: rtl/receiver.sv
// 8N1 receiver: 2-FF synchroniser, 16x oversampling, mid-bit sampling, framing check.
module receiver
    import uart_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 1
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_status
);

    localparam logic [3:0] SAMPLE_LAST = 4'(SAMPLE_POINT - 1);
    localparam logic [3:0] BIT_LAST    = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] IDX_LAST    = 3'(DATA_BITS - 1);

    // r_sync[1] is the synchronised line, r_sync[2] its previous value for edge detection.
    logic [2:0]           r_sync;
    rx_state_t            r_state;
    logic [3:0]           r_tick_cnt;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [7:0]           r_rx_data;
    logic                 r_rx_status;

    logic w_line;
    logic w_fall;
    logic w_clear;
    logic w_tick;

    assign w_line  = r_sync[1];
    assign w_fall  = r_sync[2] & ~r_sync[1];
    assign w_clear = (r_state == RX_IDLE) && w_fall;

    uart_baud_tick #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_baud_tick (
        .sysclk (sysclk),
        .reset  (reset),
        .i_clear(w_clear),
        .o_tick (w_tick)
    );

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_sync      <= 3'b111;
            r_state     <= RX_IDLE;
            r_tick_cnt  <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_status <= 1'b0;
        end else begin
            r_sync      <= {r_sync[1:0], uart_rx};
            r_rx_status <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (w_fall) begin
                        r_state    <= RX_START;
                        r_tick_cnt <= '0;
                    end
                end
                RX_START: begin
                    if (w_tick) begin
                        if (r_tick_cnt == SAMPLE_LAST) begin
                            r_tick_cnt <= '0;
                            r_bit_idx  <= '0;
                            // A line already high at mid start bit was only a glitch.
                            r_state    <= w_line ? RX_IDLE : RX_DATA;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 4'd1;
                        end
                    end
                end
                RX_DATA: begin
                    if (w_tick) begin
                        if (r_tick_cnt == BIT_LAST) begin
                            r_tick_cnt <= '0;
                            r_shift    <= {w_line, r_shift[DATA_BITS-1:1]};
                            if (r_bit_idx == IDX_LAST) begin
                                r_state <= RX_STOP;
                            end else begin
                                r_bit_idx <= r_bit_idx + 3'd1;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 4'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (w_tick) begin
                        if (r_tick_cnt == BIT_LAST) begin
                            r_tick_cnt <= '0;
                            if (w_line) begin
                                r_rx_data   <= r_shift;
                                r_rx_status <= 1'b1;
                                r_state     <= RX_IDLE;
                            end else begin
                                r_state <= RX_WAIT_HIGH;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 4'd1;
                        end
                    end
                end
                RX_WAIT_HIGH: begin
                    if (w_line) begin
                        r_state <= RX_IDLE;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_status = r_rx_status;

endmodule

// File: rtl/sender.sv
// 8N1 transmitter: accepts a byte when idle and holds each bit for BIT_CYCLES clocks.
module sender
    import uart_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = 16
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_en,
    output logic       tx_status,
    output logic       uart_tx
);

    localparam int unsigned   CW       = $clog2(BIT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

    tx_state_t            r_state;
    logic [CW-1:0]        r_cnt;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_tx_status;
    logic                 r_uart_tx;

    logic w_bit_done;

    assign w_bit_done = (r_cnt == CNT_LAST);

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_state     <= TX_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_tx_status <= 1'b1;
            r_uart_tx   <= 1'b1;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    if (tx_en && r_tx_status) begin
                        r_shift     <= tx_data;
                        r_cnt       <= '0;
                        r_tx_status <= 1'b0;
                        r_uart_tx   <= 1'b0;
                        r_state     <= TX_START;
                    end
                end
                TX_START: begin
                    if (w_bit_done) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_uart_tx <= r_shift[0];
                        r_state   <= TX_DATA;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                TX_DATA: begin
                    if (w_bit_done) begin
                        r_cnt <= '0;
                        if (r_bit_idx == IDX_LAST) begin
                            r_uart_tx <= 1'b1;
                            r_state   <= TX_STOP;
                        end else begin
                            // Shift so the next bit to send is always r_shift[1] here.
                            r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
                            r_uart_tx <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                TX_STOP: begin
                    if (w_bit_done) begin
                        r_cnt       <= '0;
                        r_tx_status <= 1'b1;
                        r_state     <= TX_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

    assign tx_status = r_tx_status;
    assign uart_tx   = r_uart_tx;

endmodule

// File: rtl/uart_baud_tick.sv
// Free-running 16x oversampling tick; i_clear realigns the count to a start-bit edge.
module uart_baud_tick #(
    parameter int unsigned TICK_CYCLES = 1
) (
    input  logic sysclk,
    input  logic reset,
    input  logic i_clear,
    output logic o_tick
);

    localparam int unsigned CW = $clog2(TICK_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == LAST);

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clear || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_phy.sv
// Byte-level 8N1 UART PHY: independent receiver and transmitter on one clock and reset.
module uart_phy
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_status,
    input  logic [7:0] tx_data,
    input  logic       tx_en,
    output logic       tx_status,
    output logic       uart_tx
);

    localparam int unsigned BIT_CYCLES  = at_least_one(CLK_FREQ / BAUD);
    localparam int unsigned TICK_CYCLES = at_least_one(CLK_FREQ / (BAUD * OVERSAMPLE));

    receiver #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_receiver (
        .sysclk   (sysclk),
        .reset    (reset),
        .uart_rx  (uart_rx),
        .rx_data  (rx_data),
        .rx_status(rx_status)
    );

    sender #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_sender (
        .sysclk   (sysclk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_en    (tx_en),
        .tx_status(tx_status),
        .uart_tx  (uart_tx)
    );

endmodule

// File: tb/tb_uart_phy.sv
// Self-checking bench for uart_phy at 16 clocks per bit, with randomized bytes and loopback.
module tb_uart_phy;

    localparam int unsigned BITC = 16;

    logic       sysclk = 1'b0;
    logic       rst_n  = 1'b0;
    logic       rx_drv = 1'b1;
    logic       lb_en  = 1'b0;
    logic       w_uart_rx;
    logic [7:0] rx_data;
    logic       rx_status;
    logic [7:0] tx_data = 8'h00;
    logic       tx_en   = 1'b0;
    logic       tx_status;
    logic       uart_tx;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor: every rx_status pulse and its byte, plus any pulse wider than one clock.
    int         cycle = 0;
    int         width_err = 0;
    int         last_pulse_cycle = 0;
    logic       prev_status = 1'b0;
    logic [7:0] rx_q[$];

    assign w_uart_rx = lb_en ? uart_tx : rx_drv;

    always #5 sysclk = ~sysclk;

    uart_phy #(
        .CLK_FREQ(1_600_000),
        .BAUD    (100_000)
    ) dut (
        .sysclk   (sysclk),
        .reset    (rst_n),
        .uart_rx  (w_uart_rx),
        .rx_data  (rx_data),
        .rx_status(rx_status),
        .tx_data  (tx_data),
        .tx_en    (tx_en),
        .tx_status(tx_status),
        .uart_tx  (uart_tx)
    );

    always @(negedge sysclk) begin
        cycle <= cycle + 1;
        if (rx_status === 1'b1) begin
            if (prev_status === 1'b1) begin
                width_err <= width_err + 1;
            end else begin
                rx_q.push_back(rx_data);
                last_pulse_cycle <= cycle;
            end
        end
        prev_status <= rx_status;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Drive one 8N1 frame on the line, LSB first, 16 clocks per bit.
    task automatic drive_rx(input logic [7:0] d, input logic stop, output int start_cyc);
        logic [9:0] frame;
        frame = {stop, d, 1'b0};
        start_cyc = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge sysclk);
            #2 rx_drv = frame[i];
            if (i == 0) start_cyc = cycle;
            repeat (BITC - 1) @(posedge sysclk);
        end
        if (!stop) begin
            @(posedge sysclk);
            #2 rx_drv = 1'b1;
        end
    endtask

    // Send one byte and sample uart_tx at every bit midpoint; optionally poke tx_en while busy.
    task automatic tx_frame_check(input logic [7:0] d, input bit inject, input string name);
        logic [9:0] exp_bits;
        logic [9:0] got_bits;
        int low;
        int nb;
        int bad;
        exp_bits = {1'b1, d, 1'b0};
        got_bits = '0;
        @(negedge sysclk);
        tx_data = d;
        tx_en   = 1'b1;
        @(posedge sysclk);
        #1 tx_en = 1'b0;
        tx_data = 8'($urandom);
        low = 0;
        nb  = 0;
        for (int c = 0; c < 400; c++) begin
            if (tx_status !== 1'b0) break;
            low++;
            if ((c % BITC) == 8 && nb < 10) begin
                got_bits[nb] = uart_tx;
                nb++;
            end
            if (inject && c == 20) begin
                tx_data = 8'h34;
                tx_en   = 1'b1;
            end
            if (inject && c == 21) tx_en = 1'b0;
            @(posedge sysclk);
            #1;
        end
        n_checks++;
        if (low != 10 * BITC) begin
            n_fail++;
            $display("FAIL %s busy_len: got %0d cycles required %0d", name, low, 10 * BITC);
        end
        n_checks++;
        if (got_bits !== exp_bits) begin
            n_fail++;
            $display("FAIL %s bits: got %b required %b (LSB=start)", name, got_bits, exp_bits);
        end
        n_checks++;
        if (uart_tx !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle_line: got %b required 1", name, uart_tx);
        end
        if (inject) begin
            bad = 0;
            for (int c = 0; c < 3 * BITC; c++) begin
                @(negedge sysclk);
                if (uart_tx !== 1'b1 || tx_status !== 1'b1) bad++;
            end
            n_checks++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL %s no_queued_frame: got %0d busy cycles required 0", name, bad);
            end
        end
    endtask

    task automatic test_reset();
        #23;
        n_checks++;
        if (uart_tx !== 1'b1 || tx_status !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_tx: got tx=%b st=%b required 1 1", uart_tx, tx_status);
        end
        n_checks++;
        if (rx_data !== 8'h00 || rx_status !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rx: got data=%h st=%b required 00 0", rx_data, rx_status);
        end
        @(negedge sysclk);
        rst_n = 1'b1;
        repeat (4) @(negedge sysclk);
    endtask

    task automatic test_reset_mid_tx();
        int edges;
        @(negedge sysclk);
        tx_data = 8'hA5;
        tx_en   = 1'b1;
        @(posedge sysclk);
        #1 tx_en = 1'b0;
        repeat (50) @(posedge sysclk);
        #3;
        n_checks++;
        if (tx_status !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_busy: got tx_status=%b required 0", tx_status);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (uart_tx !== 1'b1 || tx_status !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_abort: got tx=%b st=%b required 1 1", uart_tx, tx_status);
        end
        repeat (3) @(negedge sysclk);
        rst_n = 1'b1;
        edges = 0;
        for (int c = 0; c < 15 * BITC; c++) begin
            @(negedge sysclk);
            if (uart_tx !== 1'b1 || tx_status !== 1'b1) edges++;
        end
        n_checks++;
        if (edges != 0) begin
            n_fail++;
            $display("FAIL rst_mid_quiet: got %0d active cycles required 0", edges);
        end
    endtask

    task automatic test_tx();
        tx_frame_check(8'h55, 1'b0, "tx_55");
        tx_frame_check(8'h12, 1'b1, "tx_busy");
        for (int k = 0; k < 3; k++) tx_frame_check(8'($urandom), 1'b0, "tx_rand");
    endtask

    task automatic test_rx_c3();
        int base;
        int t0;
        int lat;
        base = rx_q.size();
        drive_rx(8'hC3, 1'b1, t0);
        repeat (20) @(negedge sysclk);
        lat = last_pulse_cycle - t0;
        n_checks++;
        if (rx_q.size() != base + 1) begin
            n_fail++;
            $display("FAIL rx_c3_count: got %0d pulses required 1", rx_q.size() - base);
        end
        n_checks++;
        if (rx_data !== 8'hC3) begin
            n_fail++;
            $display("FAIL rx_c3_data: got %h required c3", rx_data);
        end
        n_checks++;
        if (lat < 145 || lat > 160) begin
            n_fail++;
            $display("FAIL rx_c3_latency: got %0d cycles required 145..160", lat);
        end
        n_checks++;
        if (width_err != 0) begin
            n_fail++;
            $display("FAIL rx_c3_width: got %0d wide pulses required 0", width_err);
        end
    endtask

    task automatic test_rx_errors();
        int base;
        int t0;
        base = rx_q.size();
        @(posedge sysclk);
        #2 rx_drv = 1'b0;
        repeat (4) @(posedge sysclk);
        #2 rx_drv = 1'b1;
        repeat (200) @(negedge sysclk);
        n_checks++;
        if (rx_q.size() != base) begin
            n_fail++;
            $display("FAIL rx_glitch: got %0d pulses required 0", rx_q.size() - base);
        end
        drive_rx(8'($urandom), 1'b0, t0);
        repeat (40) @(negedge sysclk);
        n_checks++;
        if (rx_q.size() != base || rx_data !== 8'hC3) begin
            n_fail++;
            $display("FAIL rx_framing: got %0d pulses data=%h required 0 c3",
                     rx_q.size() - base, rx_data);
        end
        drive_rx(8'h7E, 1'b1, t0);
        repeat (20) @(negedge sysclk);
        n_checks++;
        if (rx_q.size() != base + 1 || rx_data !== 8'h7E) begin
            n_fail++;
            $display("FAIL rx_after_err: got %0d pulses data=%h required 1 7e",
                     rx_q.size() - base, rx_data);
        end
    endtask

    task automatic test_rx_random();
        logic [7:0] exp[4];
        int base;
        int t0;
        base = rx_q.size();
        for (int k = 0; k < 4; k++) begin
            exp[k] = 8'($urandom);
            drive_rx(exp[k], 1'b1, t0);
        end
        repeat (20) @(negedge sysclk);
        n_checks++;
        if (rx_q.size() != base + 4) begin
            n_fail++;
            $display("FAIL rx_rand_count: got %0d pulses required 4", rx_q.size() - base);
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (rx_q[base + k] !== exp[k]) begin
                    n_fail++;
                    $display("FAIL rx_rand_data[%0d]: got %h required %h", k, rx_q[base + k], exp[k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes[5];
        int base;
        int g;
        int acc_prev;
        bytes[0] = 8'h00;
        bytes[1] = 8'hFF;
        bytes[2] = 8'h81;
        bytes[3] = 8'($urandom);
        bytes[4] = 8'($urandom);
        @(negedge sysclk);
        lb_en = 1'b1;
        base = rx_q.size();
        acc_prev = 0;
        for (int k = 0; k < 5; k++) begin
            g = 0;
            @(negedge sysclk);
            while (tx_status !== 1'b1 && g < 400) begin
                @(negedge sysclk);
                g++;
            end
            tx_data = bytes[k];
            tx_en   = 1'b1;
            @(posedge sysclk);
            #1 tx_en = 1'b0;
            tx_data = 8'($urandom);
            if (k > 0) begin
                n_checks++;
                if (cycle - acc_prev != 10 * BITC + 1) begin
                    n_fail++;
                    $display("FAIL b2b_spacing[%0d]: got %0d cycles required %0d",
                             k, cycle - acc_prev, 10 * BITC + 1);
                end
            end
            acc_prev = cycle;
        end
        g = 0;
        while (rx_q.size() < base + 5 && g < 400) begin
            @(negedge sysclk);
            g++;
        end
        repeat (20) @(negedge sysclk);
        n_checks++;
        if (rx_q.size() != base + 5) begin
            n_fail++;
            $display("FAIL loop_count: got %0d pulses required 5", rx_q.size() - base);
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_checks++;
                if (rx_q[base + k] !== bytes[k]) begin
                    n_fail++;
                    $display("FAIL loop_data[%0d]: got %h required %h", k, rx_q[base + k], bytes[k]);
                end
            end
        end
        n_checks++;
        if (width_err != 0) begin
            n_fail++;
            $display("FAIL loop_width: got %0d wide pulses required 0", width_err);
        end
        lb_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_reset_mid_tx();
        test_tx();
        test_rx_c3();
        test_rx_errors();
        test_rx_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
